adder_response_checker: RTL and testbench
=========================================

# adder_response_checker

Hardware response checker for the adder datapath: the consuming end of the adder stimulus flow. It accepts a stream of applied operand sets together with the adder's observed outputs, recomputes the expected result, and counts vectors and mismatches. At the end of a run it reports a pass/fail verdict. It sits downstream of the adder under test, on the same clock, and lets directed stimulus runs self-check on-chip instead of through waveform inspection.

## Interface
- WIDTH, 2, operand and sum width in bits
- CNT_W, 8, width of the vector-count and error-count registers
---
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled in IDLE and DONE only
- num_vec  in  CNT_W  number of vectors in the run; latched on accepted start
- in_valid  in  1  a/b/cin/sum/c_out carry a vector to check
- in_ready  out  1  checker accepts a vector this cycle
- a, b  in  WIDTH  operands applied to the adder
- cin  in  1  carry-in applied to the adder
- sum  in  WIDTH  adder sum output observed
- c_out  in  1  adder carry-out observed
- busy  out  1  run in progress (state RUN)
- done  out  1  run finished (state DONE)
- pass  out  1  run passed; meaningful only while done=1
- mismatch  out  1  one-cycle pulse, registered, when the last accepted vector failed
- vec_count  out  CNT_W  vectors accepted in current run
- err_count  out  CNT_W  failing vectors in current run
- fail_vec  out  3*WIDTH+2  first failing vector, packed {a,b,cin,sum,c_out}

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - in_ready=0.
  - On start=1: latch num_vec, clear vec_count, err_count and fail_vec.
  - If num_vec≠0, go to RUN. If num_vec=0, go directly to DONE.
- **RUN**
  - in_ready=1. A vector is accepted on any edge with in_valid & in_ready.
  - start is ignored.
  - Expected result = a + b + cin, computed at WIDTH+1 bits, zero-extended; no overflow is possible.
  - Fail when {c_out,sum} ≠ expected.
  - On each accepted vector:
    - vec_count increments.
    - On fail, err_count increments and mismatch pulses.
  - When the accepted vector makes vec_count equal the latched num_vec, go to DONE on the same edge.
- **DONE**
  - in_ready=0, done=1, pass = (err_count==0).
  - Counters hold.
  - start=1 restarts exactly as from IDLE.
- Counters never exceed the latched num_vec, so saturation logic is not needed.
- Changing num_vec during RUN has no effect.
- in_valid outside RUN is ignored; no vector is counted.

## Timing
- **Reset values:** in_ready, busy, done, pass and mismatch are 0; vec_count, err_count and fail_vec are 0.
- **Reset mid-run:** an asynchronous assert at any time returns the block to IDLE with all outputs at reset values on the next evaluation, not at a clock edge.
- **Start:** accepted at edge k. busy=1 and in_ready=1 from edge k. For num_vec=0, done=1 and pass=1 from edge k.
- **Per vector:** zero-latency acceptance. vec_count, err_count and mismatch reflect the vector accepted at edge k, all visible after edge k.
- **mismatch:** high for exactly one cycle per failing vector. Back-to-back failures give mismatch high on consecutive cycles.
- **Last vector:** the final vector accepted at edge k leaves busy=0, done=1 and in_ready=0 after edge k. done and the final counts appear together.

## Configuration
- **ADDER_CHK_FAIL_LOG_EN defined:** fail_vec captures {a,b,cin,sum,c_out} of the first failing vector in the run. It holds that value until the next accepted start or reset; later failures do not overwrite it.
- **Not defined:** fail_vec is tied to 0 and no capture registers are built. All other behaviour is identical.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle with random inputs -> every output is 0 immediately and state is IDLE; in_ready stays 0 with in_valid=1.
- **Clean run:** start with num_vec=4, WIDTH=2. Feed back-to-back (a,b,cin,c_out,sum) = (0,0,0,0,00), (1,3,0,1,00), (3,3,1,1,11), (2,1,1,1,00) -> done=1 right after the 4th edge, pass=1, vec_count=4, err_count=0, mismatch never high.
- **Single error:** same run, but the 2nd vector is presented with c_out=0, sum=00 -> mismatch high exactly one cycle, err_count=1, pass=0 at done. With the macro, fail_vec={01,11,0,00,0}; without it, fail_vec=0.
- **Gaps and ignores:**
  - num_vec=3 with in_valid gaps of 0–3 cycles -> only valid cycles are counted, done after the 3rd.
  - start pulsed during RUN -> ignored.
  - num_vec=0 -> done=1 and pass=1 one edge after start.
- **Reset mid-run:** assert rst_n=0 after 2 of 4 vectors -> IDLE, counters 0. A following start with num_vec=1 and a correct vector gives done=1, pass=1.
- **Restart from DONE:** a failing run ends with err_count=2; start again with num_vec=2 and correct vectors -> counters clear at start, final err_count=0, pass=1, fail_vec cleared.

Source files
------------

// File: rtl/adder_response_checker.sv
// On-chip response checker for the adder datapath: recomputes a+b+cin for each
// accepted vector, counts vectors/failures, and reports a verdict. ADDER_CHK_FAIL_LOG_EN enables first-failure capture.
module adder_response_checker #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_vec,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 c_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [3*WIDTH+1:0]   fail_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [WIDTH:0]   expected;
    logic             vec_fail;
    logic             accept;
    logic             restart;
    logic [CNT_W-1:0] vec_next;
    logic [CNT_W-1:0] err_next;

    // WIDTH+1 bits holds the full a+b+cin range, so no overflow handling.
    assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign vec_fail = ({c_out, sum} != expected);
    assign accept   = (state == RUN) && in_valid && in_ready;
    assign restart  = (state != RUN) && start;
    assign vec_next = vec_count + CNT_W'(1);
    assign err_next = err_count + CNT_W'(vec_fail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_lat   <= '0;
            vec_count <= '0;
            err_count <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_lat   <= num_vec;
                        vec_count <= '0;
                        err_count <= '0;
                        if (num_vec == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        vec_count <= vec_next;
                        err_count <= err_next;
                        mismatch  <= vec_fail;
                        // Final vector: verdict and counts land on the same edge.
                        if (vec_next == num_lat) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (err_next == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_CHK_FAIL_LOG_EN
    // Only the first failure of a run is kept; err_count==0 marks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fail_vec <= '0;
        else if (restart)
            fail_vec <= '0;
        else if (accept && vec_fail && (err_count == '0))
            fail_vec <= {a, b, cin, sum, c_out};
    end
`else
    assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: directed runs, a behavioural run model,
// and a per-cycle compare against it plus literal spot checks.
module tb_adder_response_checker;
    localparam int W = 2;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [C-1:0]   num_vec;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a, b, sum;
    logic           cin, c_out;
    logic           busy, done, pass, mismatch;
    logic [C-1:0]   vec_count, err_count;
    logic [3*W+1:0] fail_vec;

    int n_chk  = 0;
    int n_pass = 0;
    int n_mis  = 0;

    adder_response_checker #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .sum(sum), .c_out(c_out), .busy(busy), .done(done), .pass(pass),
        .mismatch(mismatch), .vec_count(vec_count), .err_count(err_count),
        .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit is_bad(input int ia, input int ib, input int ic,
                                  input int ico, input int isum);
        return (ia + ib + ic) != (ico * (1 << W) + isum);
    endfunction

    // Run model: phase 0=idle, 1=running, 2=finished.
    int           m_phase, m_target, m_vec, m_err;
    logic         m_mis;
    logic [3*W+1:0] m_first;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_target <= 0; m_vec <= 0; m_err <= 0;
            m_mis <= 1'b0; m_first <= '0;
        end else begin
            m_mis <= 1'b0;
            if (m_phase != 1 && start) begin
                m_target <= int'(num_vec);
                m_vec <= 0; m_err <= 0; m_first <= '0;
                m_phase <= (num_vec == 0) ? 2 : 1;
            end else if (m_phase == 1 && in_valid) begin
                m_vec <= m_vec + 1;
                if (is_bad(int'(a), int'(b), int'(cin), int'(c_out), int'(sum))) begin
                    m_err <= m_err + 1;
                    m_mis <= 1'b1;
                    if (m_err == 0) m_first <= {a, b, cin, sum, c_out};
                end
                if (m_vec + 1 == m_target) m_phase <= 2;
            end
        end
    end

    logic [3*W+1:0] exp_fail;
`ifdef ADDER_CHK_FAIL_LOG_EN
    assign exp_fail = m_first;
`else
    assign exp_fail = '0;
`endif

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_phase == 1));
        chk("busy",      32'(busy),      32'(m_phase == 1));
        chk("done",      32'(done),      32'(m_phase == 2));
        chk("pass",      32'(pass),      32'(m_phase == 2 && m_err == 0));
        chk("mismatch",  32'(mismatch),  32'(m_mis));
        chk("vec_count", 32'(vec_count), 32'(m_vec));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("fail_vec",  32'(fail_vec),  32'(exp_fail));
        if (mismatch) n_mis++;
    end

    task automatic do_start(input int n);
        start = 1'b1; num_vec = C'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic vec(input logic [1:0] va, input logic [1:0] vb, input logic vc,
                       input logic vco, input logic [1:0] vs);
        a = va; b = vb; cin = vc; c_out = vco; sum = vs; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdy"},  32'(in_ready),  0);
        chk({nm, "_busy"}, 32'(busy),      0);
        chk({nm, "_done"}, 32'(done),      0);
        chk({nm, "_pass"}, 32'(pass),      0);
        chk({nm, "_mis"},  32'(mismatch),  0);
        chk({nm, "_vec"},  32'(vec_count), 0);
        chk({nm, "_err"},  32'(err_count), 0);
        chk({nm, "_fv"},   32'(fail_vec),  0);
    endtask

    int mis0;
    logic [3*W+1:0] lit_fail;

    initial begin
        rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'b1; sum = '0; c_out = 1'b0;
        #7;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        idle(2);

        // Clean run, then a stray vector in DONE that must be ignored.
        mis0 = n_mis;
        do_start(4);
        vec(2'd0, 2'd0, 1'b0, 1'b0, 2'b00);
        vec(2'd1, 2'd3, 1'b0, 1'b1, 2'b00);
        vec(2'd3, 2'd3, 1'b1, 1'b1, 2'b11);
        vec(2'd2, 2'd1, 1'b1, 1'b1, 2'b00);
        chk("clean_done", 32'(done), 1);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_vec",  32'(vec_count), 4);
        chk("clean_err",  32'(err_count), 0);
        vec(2'd1, 2'd1, 1'b0, 1'b1, 2'b11);
        chk("clean_mis_cnt", 32'(n_mis - mis0), 0);
        chk("done_ignore_vec", 32'(vec_count), 4);

        // Single error on vector 2.
        mis0 = n_mis;
        do_start(4);
        vec(2'd0, 2'd0, 1'b0, 1'b0, 2'b00);
        vec(2'd1, 2'd3, 1'b0, 1'b0, 2'b00);
        chk("err_mis_pulse", 32'(mismatch), 1);
        vec(2'd3, 2'd3, 1'b1, 1'b1, 2'b11);
        chk("err_mis_low", 32'(mismatch), 0);
        vec(2'd2, 2'd1, 1'b1, 1'b1, 2'b00);
        chk("err_done", 32'(done), 1);
        chk("err_pass", 32'(pass), 0);
        chk("err_cnt",  32'(err_count), 1);
        chk("err_mis_cnt", 32'(n_mis - mis0), 1);
`ifdef ADDER_CHK_FAIL_LOG_EN
        lit_fail = 8'b01_11_0_00_0;
`else
        lit_fail = '0;
`endif
        chk("err_fail_vec", 32'(fail_vec), 32'(lit_fail));

        // Gaps, plus start/num_vec changes mid-run that must be ignored.
        do_start(3);
        vec(2'd1, 2'd1, 1'b0, 1'b0, 2'b10);
        start = 1'b1; num_vec = 8'd1; idle(1); start = 1'b0;
        vec(2'd3, 2'd0, 1'b0, 1'b0, 2'b11);
        idle(3);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_vec",  32'(vec_count), 2);
        vec(2'd2, 2'd3, 1'b1, 1'b1, 2'b10);
        wait_done("gap_done");
        chk("gap_vec_final", 32'(vec_count), 3);
        chk("gap_pass", 32'(pass), 1);

        // Zero-length run.
        do_start(0);
        chk("zero_done", 32'(done), 1);
        chk("zero_pass", 32'(pass), 1);
        chk("zero_busy", 32'(busy), 0);

        // Reset mid-run after 2 of 4 vectors.
        do_start(4);
        vec(2'd1, 2'd0, 1'b0, 1'b0, 2'b01);
        vec(2'd1, 2'd1, 1'b1, 1'b0, 2'b11);
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        do_start(1);
        vec(2'd3, 2'd2, 1'b1, 1'b1, 2'b10);
        chk("post_rst_done", 32'(done), 1);
        chk("post_rst_pass", 32'(pass), 1);

        // Back-to-back failures, then restart from DONE.
        mis0 = n_mis;
        do_start(3);
        vec(2'd2, 2'd2, 1'b0, 1'b0, 2'b00);
        vec(2'd3, 2'd0, 1'b1, 1'b0, 2'b11);
        vec(2'd0, 2'd1, 1'b0, 1'b0, 2'b01);
        chk("two_err_cnt",  32'(err_count), 2);
        chk("two_err_pass", 32'(pass), 0);
        chk("two_err_mis",  32'(n_mis - mis0), 2);
        do_start(2);
        chk("rs_vec_clr",  32'(vec_count), 0);
        chk("rs_err_clr",  32'(err_count), 0);
        chk("rs_fv_clr",   32'(fail_vec), 0);
        vec(2'd1, 2'd2, 1'b1, 1'b1, 2'b00);
        vec(2'd3, 2'd1, 1'b0, 1'b1, 2'b00);
        chk("rs_done", 32'(done), 1);
        chk("rs_pass", 32'(pass), 1);
        chk("rs_err",  32'(err_count), 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
